// File: rtl/dcache_pkg.sv
// Shared types and helpers for the data-cache BRAM sequencer.
package dcache_pkg;

  localparam int LINE_WORDS   = 8;
  localparam int OFFSET_BITS  = 3;
  // The BRAM banks are built for a 7-bit line index, so the word address is fixed at 10 bits.
  localparam int CACHE_ADDR_W = 10;
  localparam int LINE_IDX_W   = CACHE_ADDR_W - OFFSET_BITS;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_RSP,
    ST_EVICT_RD,
    ST_EVICT_CAP,
    ST_EVICT_SEND,
    ST_REFILL_REQ,
    ST_REFILL_DATA,
    ST_REFILL_WR,
    ST_REPLAY
  } state_t;

  function automatic logic [LINE_IDX_W-1:0] line_idx(input logic [CACHE_ADDR_W-1:0] addr);
    return addr[CACHE_ADDR_W-1:OFFSET_BITS];
  endfunction

  function automatic logic [CACHE_ADDR_W-1:0] line_base(input logic [LINE_IDX_W-1:0] line);
    return {line, {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_line_buf.sv
// Refill assembler: collects the eight memory beats of a line, word 0 first.
module dcache_line_buf
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             beat_valid,
  input  logic [DATA_WIDTH-1:0]            beat_data,
  output logic [DATA_WIDTH*LINE_WORDS-1:0] line,
  output logic                             last_beat
);

  logic [OFFSET_BITS-1:0] cnt;

  assign last_beat = beat_valid && (cnt == OFFSET_BITS'(LINE_WORDS - 1));

  // Drop each accepted beat into the slot named by the beat counter.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      line <= '0;
      cnt  <= '0;
    end else if (beat_valid) begin
      line[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= beat_data;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dcache_data_ctrl.sv
// Data-cache BRAM sequencer: CPU hits, dirty-line eviction and 8-beat refill
// share the single BRAM port.
//
//   state          | meaning
//   ---------------+--------------------------------------------------------
//   ST_IDLE        | accept requests; hits go straight to the BRAM
//   ST_LOAD_RSP    | BRAM word is on bram_dout; register it as the response
//   ST_EVICT_RD    | read the victim line at its base address
//   ST_EVICT_CAP   | capture the victim line into wb_data
//   ST_EVICT_SEND  | hold the write-back until wb_ready
//   ST_REFILL_REQ  | request the line from memory until mem_rd_ready
//   ST_REFILL_DATA | collect eight refill beats
//   ST_REFILL_WR   | write the assembled line into the BRAM
//   ST_REPLAY      | re-run the held request as a hit
module dcache_data_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [3:0]              req_ben,
  input  logic                    req_miss,
  input  logic                    req_dirty,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   bram_raddr,
  output logic                    bram_re,
  output logic [ADDR_WIDTH-1:0]   bram_waddr,
  output logic                    bram_we,
  output logic [DATA_WIDTH-1:0]   bram_din,
  output logic                    bram_store,
  output logic                    bram_hit_write,
  output logic [3:0]              bram_byte_ben,
  output logic [DATA_WIDTH*8-1:0] bram_din_all,
  input  logic [DATA_WIDTH-1:0]   bram_dout,
  input  logic [DATA_WIDTH*8-1:0] bram_dout_all,
  output logic                    mem_rd_valid,
  input  logic                    mem_rd_ready,
  output logic [ADDR_WIDTH-4:0]   mem_rd_line,
  input  logic                    mem_rdata_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [ADDR_WIDTH-4:0]   wb_line,
  output logic [DATA_WIDTH*8-1:0] wb_data
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic                  hold_we;
  logic [DATA_WIDTH-1:0] hold_wdata;
  logic [3:0]            hold_ben;

  logic accept;
  logic hit_req;
  logic beat_valid;
  logic last_beat;

  assign accept     = req_valid && req_ready;
  assign hit_req    = accept && !req_miss;
  // Beats outside the refill window are ignored entirely.
  assign beat_valid = (state == ST_REFILL_DATA) && mem_rdata_valid;

  dcache_line_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_line_buf (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == ST_REFILL_REQ),
    .beat_valid (beat_valid),
    .beat_data  (mem_rdata),
    .line       (bram_din_all),
    .last_beat  (last_beat)
  );

  // Sequencer state, held request and all registered handshake/data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      mem_rd_valid <= 1'b0;
      mem_rd_line  <= '0;
      wb_valid     <= 1'b0;
      wb_line      <= '0;
      wb_data      <= '0;
      hold_addr    <= '0;
      hold_we      <= 1'b0;
      hold_wdata   <= '0;
      hold_ben     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            hold_addr  <= req_addr;
            hold_we    <= req_we;
            hold_wdata <= req_wdata;
            hold_ben   <= req_ben;
            if (!req_miss) begin
              if (req_we) begin
                rsp_valid <= 1'b1;
              end else begin
                req_ready <= 1'b0;
                state     <= ST_LOAD_RSP;
              end
            end else if (req_dirty) begin
              req_ready <= 1'b0;
              state     <= ST_EVICT_RD;
            end else begin
              req_ready    <= 1'b0;
              mem_rd_valid <= 1'b1;
              mem_rd_line  <= line_idx(req_addr);
              state        <= ST_REFILL_REQ;
            end
          end
        end
        ST_LOAD_RSP: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= bram_dout;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_EVICT_RD: begin
          state <= ST_EVICT_CAP;
        end
        ST_EVICT_CAP: begin
          wb_data  <= bram_dout_all;
          wb_line  <= line_idx(hold_addr);
          wb_valid <= 1'b1;
          state    <= ST_EVICT_SEND;
        end
        ST_EVICT_SEND: begin
          if (wb_ready) begin
            wb_valid     <= 1'b0;
            mem_rd_valid <= 1'b1;
            mem_rd_line  <= line_idx(hold_addr);
            state        <= ST_REFILL_REQ;
          end
        end
        ST_REFILL_REQ: begin
          if (mem_rd_ready) begin
            mem_rd_valid <= 1'b0;
            state        <= ST_REFILL_DATA;
          end
        end
        ST_REFILL_DATA: begin
          if (last_beat) state <= ST_REFILL_WR;
        end
        ST_REFILL_WR: begin
          state <= ST_REPLAY;
        end
        ST_REPLAY: begin
          if (hold_we) begin
            rsp_valid <= 1'b1;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            state <= ST_LOAD_RSP;
          end
        end
        default: begin
          req_ready <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // BRAM command port: IDLE hits issue in the acceptance cycle so a load answers two cycles later.
  always_comb begin
    bram_re        = 1'b0;
    bram_we        = 1'b0;
    bram_store     = 1'b0;
    bram_hit_write = 1'b0;
    bram_raddr     = hold_addr;
    bram_waddr     = hold_addr;
    bram_din       = hold_wdata;
    bram_byte_ben  = hold_ben;
    case (state)
      ST_IDLE: begin
        bram_raddr    = req_addr;
        bram_waddr    = req_addr;
        bram_din      = req_wdata;
        bram_byte_ben = req_ben;
        if (hit_req) begin
          bram_re    = !req_we;
          bram_we    = req_we;
          bram_store = req_we;
        end
      end
      ST_EVICT_RD: begin
        bram_re    = 1'b1;
        bram_raddr = line_base(line_idx(hold_addr));
      end
      ST_REFILL_WR: begin
        bram_we        = 1'b1;
        bram_hit_write = 1'b1;
        bram_waddr     = line_base(line_idx(hold_addr));
      end
      ST_REPLAY: begin
        bram_re    = !hold_we;
        bram_we    = hold_we;
        bram_store = hold_we;
      end
      default: ;
    endcase
    if (rst) begin
      bram_re        = 1'b0;
      bram_we        = 1'b0;
      bram_store     = 1'b0;
      bram_hit_write = 1'b0;
      bram_raddr     = '0;
      bram_waddr     = '0;
      bram_din       = '0;
      bram_byte_ben  = '0;
    end
  end

endmodule

// File: tb/tb_dcache_data_ctrl.sv
// Directed bench for dcache_data_ctrl with a behavioural BRAM and a response scoreboard.
module tb_dcache_data_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0, req_we = 1'b0, req_miss = 1'b0, req_dirty = 1'b0;
  logic [9:0]   req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic [3:0]   req_ben = '0;
  logic         req_ready, rsp_valid;
  logic [31:0]  rsp_rdata;
  logic [9:0]   bram_raddr, bram_waddr;
  logic         bram_re, bram_we, bram_store, bram_hit_write;
  logic [31:0]  bram_din;
  logic [3:0]   bram_byte_ben;
  logic [255:0] bram_din_all;
  logic [31:0]  bram_dout = '0;
  logic [255:0] bram_dout_all = '0;
  logic         mem_rd_valid, mem_rd_ready = 1'b0;
  logic [6:0]   mem_rd_line;
  logic         mem_rdata_valid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         wb_valid, wb_ready = 1'b0;
  logic [6:0]   wb_line;
  logic [255:0] wb_data;

  dcache_data_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ben(req_ben), .req_miss(req_miss), .req_dirty(req_dirty),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bram_raddr(bram_raddr), .bram_re(bram_re), .bram_waddr(bram_waddr), .bram_we(bram_we),
    .bram_din(bram_din), .bram_store(bram_store), .bram_hit_write(bram_hit_write),
    .bram_byte_ben(bram_byte_ben), .bram_din_all(bram_din_all),
    .bram_dout(bram_dout), .bram_dout_all(bram_dout_all),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_line(mem_rd_line),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_line(wb_line), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        is_load;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  int           hw_cnt = 0, hw_beats = 0, st_cnt = 0, excl_viol = 0, beats_sent = 0;
  logic [255:0] hw_line = '0;
  logic [9:0]   hw_addr = '0, st_addr = '0, rd_addr = '0;
  logic         st_hw = 1'b0;
  logic [31:0]  mem [0:1023];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  // Behavioural BRAM; contents are (re)seeded while reset is held.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[10'h015] = 32'hDEADBEEF;
      mem[10'h0A3] = 32'hAABBCCDD;
      for (int k = 0; k < 8; k++) mem[10'h3F8 + k] = 32'hA000 + 32'(k);
    end else begin
      if (bram_re) begin
        bram_dout <= mem[bram_raddr];
        for (int k = 0; k < 8; k++) bram_dout_all[k*32 +: 32] <= mem[{bram_raddr[9:3], 3'(k)}];
      end
      if (bram_we && bram_hit_write) begin
        for (int k = 0; k < 8; k++) mem[{bram_waddr[9:3], 3'(k)}] = bram_din_all[k*32 +: 32];
      end else if (bram_we && bram_store) begin
        for (int b = 0; b < 4; b++)
          if (bram_byte_ben[b]) mem[bram_waddr][b*8 +: 8] = bram_din[b*8 +: 8];
      end
    end
  end

  // Observe BRAM traffic and score responses.
  always @(negedge clk) begin
    exp_t e;
    if (bram_re && bram_we) excl_viol++;
    if (bram_re) rd_addr = bram_raddr;
    if (bram_we && bram_hit_write) begin
      hw_cnt++;
      hw_line  = bram_din_all;
      hw_addr  = bram_waddr;
      hw_beats = beats_sent;
    end
    if (bram_we && bram_store) begin
      st_cnt++;
      st_addr = bram_waddr;
      st_hw   = bram_hit_write;
    end
    if (rsp_valid) begin
      chk("rsp_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.is_load) chk("rsp_rdata", rsp_rdata, e.data);
      end
    end
  end

  task automatic issue(input logic we, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] ben, input logic miss, input logic dirty);
    bit ok = 0;
    req_we = we; req_addr = a; req_wdata = d; req_ben = ben;
    req_miss = miss; req_dirty = dirty; req_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("req_accept", ok, 1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && req_ready) begin ok = 1; break; end
    end
    chk(tag, ok, 1);
  endtask

  task automatic refill(input logic [6:0] line, input logic [31:0] base,
                        input int gap, input int nbeats);
    bit seen = 0;
    int n;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_rd_valid) begin seen = 1; break; end
    end
    chk("mem_rd_seen", seen, 1);
    chk("mem_rd_line", mem_rd_line, line);
    @(posedge clk); #1 mem_rd_ready = 1'b1;
    @(posedge clk); #1 mem_rd_ready = 1'b0;
    n = hw_cnt;
    beats_sent = 0;
    for (int k = 0; k < nbeats; k++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata = base + 32'(k);
      @(posedge clk); #1;
      beats_sent++;
      mem_rdata_valid = 1'b0;
      mem_rdata = 32'h0BAD;
      repeat (gap) begin @(posedge clk); #1; end
    end
    if (nbeats == 8) begin
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (hw_cnt != n) begin seen = 1; break; end
      end
      chk("hit_write_seen", seen, 1);
      @(negedge clk);
      chk("hit_write_once", hw_cnt, n + 1);
      chk("hit_write_after_8_beats", hw_beats, 8);
      chk("hit_write_addr", hw_addr, {line, 3'b000});
      chk("hit_write_line", hw_line, make_line(base));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valids", {req_ready, rsp_valid, bram_re, bram_we, bram_store, bram_hit_write,
                         mem_rd_valid, wb_valid}, 8'h00);
    chk("reset_regs", {rsp_rdata, mem_rd_line, wb_line}, 0);
    chk("reset_wb_data", wb_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", req_ready, 1);

    // Hit load: command in acceptance cycle, response two cycles later.
    e = '{is_load: 1'b1, data: 32'hDEADBEEF}; q.push_back(e);
    req_we = 0; req_addr = 10'h015; req_miss = 0; req_dirty = 0; req_valid = 1;
    @(negedge clk);
    chk("load_c0_re_addr", {req_ready, bram_re, bram_we, bram_raddr}, {1'b1, 1'b1, 1'b0, 10'h015});
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    chk("load_c1", {rsp_valid, req_ready}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("load_c2", {rsp_valid, req_ready, rsp_rdata}, {2'b11, 32'hDEADBEEF});
    @(posedge clk); #1;

    // Hit store, then a load of the same word in the very next cycle.
    e = '{is_load: 1'b0, data: 32'h0}; q.push_back(e);
    req_we = 1; req_addr = 10'h0A3; req_wdata = 32'h11223344; req_ben = 4'b0011; req_valid = 1;
    @(negedge clk);
    chk("store_cmd", {bram_we, bram_store, bram_hit_write, bram_re, bram_waddr, bram_byte_ben, bram_din},
        {4'b1100, 10'h0A3, 4'b0011, 32'h11223344});
    @(posedge clk); #1;
    e = '{is_load: 1'b1, data: 32'hAABB3344}; q.push_back(e);
    req_we = 0; req_wdata = 0; req_ben = 0;
    @(negedge clk);
    chk("store_rsp_and_load_issue", {rsp_valid, req_ready, bram_re}, 3'b111);
    @(posedge clk); #1 req_valid = 0;
    wait_idle("store_load_done");

    // Clean miss load with back-to-back beats.
    e = '{is_load: 1'b1, data: 32'h100}; q.push_back(e);
    issue(1'b0, 10'h048, 32'h0, 4'h0, 1'b1, 1'b0);
    refill(7'h09, 32'h100, 0, 8);
    wait_idle("clean_miss_done");
    chk("replay_read_addr", rd_addr, 10'h048);

    // Dirty miss store with a stalled write-back.
    e = '{is_load: 1'b0, data: 32'h0}; q.push_back(e);
    issue(1'b1, 10'h3F9, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1);
    begin
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (wb_valid) begin seen = 1; break; end
      end
      chk("wb_valid_seen", seen, 1);
      for (int i = 0; i < 5; i++) begin
        chk("wb_hold_valid_line", {wb_valid, mem_rd_valid, wb_line}, {2'b10, 7'h7F});
        chk("wb_hold_data", wb_data, make_line(32'hA000));
        if (i < 4) @(negedge clk);
      end
      wb_ready = 1'b1;
      @(posedge clk); #1 wb_ready = 1'b0;
    end
    refill(7'h7F, 32'h200, 0, 8);
    wait_idle("dirty_miss_done");
    chk("replay_store", {st_addr, st_hw}, {10'h3F9, 1'b0});
    e = '{is_load: 1'b1, data: 32'hCAFEF00D}; q.push_back(e);
    issue(1'b0, 10'h3F9, 32'h0, 4'h0, 1'b0, 1'b0);
    wait_idle("reload_stored");
    e = '{is_load: 1'b1, data: 32'h202}; q.push_back(e);
    issue(1'b0, 10'h3FA, 32'h0, 4'h0, 1'b0, 1'b0);
    wait_idle("reload_refilled");

    // Refill beats arriving every third cycle.
    e = '{is_load: 1'b1, data: 32'h305}; q.push_back(e);
    issue(1'b0, 10'h1C5, 32'h0, 4'h0, 1'b1, 1'b0);
    refill(7'h38, 32'h300, 2, 8);
    wait_idle("gapped_refill_done");

    // Reset in the middle of a refill, then a fresh refill.
    issue(1'b0, 10'h2A2, 32'h0, 4'h0, 1'b1, 1'b0);
    refill(7'h54, 32'h500, 0, 4);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midreset_valids", {req_ready, rsp_valid, bram_re, bram_we, bram_store, bram_hit_write,
                            mem_rd_valid, wb_valid}, 8'h00);
    chk("midreset_regs", {rsp_rdata, mem_rd_line, wb_line}, 0);
    chk("midreset_wb_data", wb_data, 0);
    @(posedge clk); #1;
    chk("midreset_idle", req_ready, 1);
    e = '{is_load: 1'b1, data: 32'h406}; q.push_back(e);
    issue(1'b0, 10'h2A6, 32'h0, 4'h0, 1'b1, 1'b0);
    refill(7'h54, 32'h400, 0, 8);
    wait_idle("post_reset_refill_done");

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", q.size(), 0);
    chk("re_we_exclusive", excl_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_data_ctrl.md
Name: dcache_data_ctrl

Overview:
- Sequencer for the 4-bank, line-wide data cache BRAM (8 words per line, line index = addr[ADDR_WIDTH-1:3]).
- Arbitrates the single BRAM port between three users:
  - CPU load/store hits.
  - Dirty-line eviction reads.
  - 8-beat memory refill writes.
- Hit/miss/dirty is decided upstream by tag logic and arrives with each request.

Parameters:
ADDR_WIDTH, 10, word-index width of BRAM address; line index = upper ADDR_WIDTH-3 bits
DATA_WIDTH, 32, word width; line = DATA_WIDTH*8 bits
Only the default ADDR_WIDTH is supported; the BRAM banks are fixed at a 7-bit line index.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  CPU request valid
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1=store, 0=load
req_addr  in  ADDR_WIDTH  word index
req_wdata  in  DATA_WIDTH  store data
req_ben  in  4  store byte enables
req_miss  in  1  line not present
req_dirty  in  1  victim line dirty (meaningful when req_miss)
rsp_valid  out  1  load data / store done, one-cycle pulse
rsp_rdata  out  DATA_WIDTH  load data
bram_raddr  out  ADDR_WIDTH  BRAM read address
bram_re  out  1  BRAM read enable
bram_waddr  out  ADDR_WIDTH  BRAM write address
bram_we  out  1  BRAM write enable
bram_din  out  DATA_WIDTH  store word
bram_store  out  1  select replicated store word
bram_hit_write  out  1  full-line write
bram_byte_ben  out  4  store byte enables
bram_din_all  out  DATA_WIDTH*8  refill line
bram_dout  in  DATA_WIDTH  selected word, 1 cycle after read
bram_dout_all  in  DATA_WIDTH*8  full line, 1 cycle after read
mem_rd_valid  out  1  refill request
mem_rd_ready  in  1  refill request accepted
mem_rd_line  out  ADDR_WIDTH-3  line index to fetch
mem_rdata_valid  in  1  refill beat valid (always accepted)
mem_rdata  in  DATA_WIDTH  refill beat, word 0 first
wb_valid  out  1  eviction line valid
wb_ready  in  1  eviction accepted
wb_line  out  ADDR_WIDTH-3  evicted line index
wb_data  out  DATA_WIDTH*8  evicted line

Behaviour:
- Reset: state=IDLE. Every valid/enable output is 0: req_ready, rsp_valid, bram_re, bram_we, bram_store, bram_hit_write, mem_rd_valid, wb_valid. All data/address registers are 0.
- A reset in any state aborts the operation and discards the beat counter and line buffer.
- Request register: on acceptance, addr/we/wdata/ben are captured and held for replay.
- States:
  - IDLE: req_ready=1.
    - Hit load: bram_re=1, raddr=req_addr → LOAD_RSP.
    - Hit store: bram_we=1, bram_store=1, bram_hit_write=0, waddr=req_addr, byte_ben=req_ben, din=req_wdata. rsp_valid=1 next cycle; stay IDLE.
    - Miss & dirty → EVICT_RD.
    - Miss & clean → REFILL_REQ.
  - LOAD_RSP: rsp_valid=1, rsp_rdata=bram_dout → IDLE. Load hit latency is 2 cycles from acceptance.
  - EVICT_RD: bram_re=1 with the line base address → EVICT_CAP.
  - EVICT_CAP: capture bram_dout_all into wb_data; wb_valid=1 → EVICT_SEND.
  - EVICT_SEND: hold wb_valid/wb_line/wb_data stable until wb_ready → REFILL_REQ.
  - REFILL_REQ: mem_rd_valid=1 until mem_rd_ready → REFILL_DATA.
  - REFILL_DATA:
    - Each mem_rdata_valid stores the beat into word slot cnt of the line buffer; cnt is 3 bits and increments.
    - The beat arriving with cnt=7 → REFILL_WR.
  - REFILL_WR: bram_we=1, bram_hit_write=1, bram_store=0, bram_din_all=line buffer, waddr=line base → REPLAY.
  - REPLAY: re-execute the held request as a hit, exactly as in IDLE but from registers.
    - Load → LOAD_RSP.
    - Store → write + rsp_valid next cycle → IDLE.
- req_ready=0 in every state except IDLE.
- bram_re and bram_we are never both 1 in a cycle.
- Exactly one rsp_valid pulse per accepted request.
- A store immediately followed by a load to the same word returns the stored data, because the write completes before the read is issued.
- mem_rdata_valid outside REFILL_DATA is ignored.

Decomposition:
- Package dcache_pkg holds:
  - State enum typedef.
  - LINE_WORDS=8, OFFSET_BITS=3.
  - Line-index slice function.
- One sub-module: dcache_line_buf. It is the 8×DATA_WIDTH refill assembler with beat counter, last-beat flag and clear.

Test Plan:
- Hit load at addr 0x015 with bram_dout=0xDEADBEEF → bram_re at cycle 0, rsp_valid=1 with rsp_rdata=0xDEADBEEF at cycle 2, req_ready high again at cycle 2.
- Hit store at addr 0x0A3, wdata 0x11223344, ben 4'b0011 → one cycle with bram_we=1, store=1, hit_write=0, waddr=0x0A3, byte_ben=0011; rsp_valid next cycle.
- Clean miss load at 0x048, beats 0x100..0x107 → mem_rd_line=0x09; one hit_write cycle with din_all word k=0x100+k, waddr=0x048; replay read; rsp_valid.
- Dirty miss store at 0x3F9 with wb_ready held low 5 cycles → wb_valid/wb_line=0x7F/wb_data stable for 5 cycles, then refill, then store write to 0x3F9 with store=1.
- Refill beats with idle gaps (valid every 3rd cycle) → line buffer order correct; exactly 8 beats consumed; no early REFILL_WR.
- rst asserted in REFILL_DATA after 4 beats → next cycle all outputs 0, state IDLE; a new clean miss refill fills all 8 slots correctly.
